// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and constants
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_BYTE_W          = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd6;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud counter 0..CLKS_PER_BIT-1 with clear and bit_tick
// Shared between the TX drain and the future RX block.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 bit_tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - pops TX FIFO words and serialises the low byte as a UART frame
// UART_TX_PARITY_EN inserts a parity bit (even, or odd with PARITY_ODD=1) before the stop bits.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1,
    parameter int CNT_WIDTH    = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  uart_rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam logic [2:0]           LAST_BIT  = 3'(UART_BYTE_W - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] PRE_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 2);

    logic [2:0]             state;
    logic [UART_BYTE_W-1:0] shift_reg;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_nxt;
    logic                   stop_idx;
    logic [CNT_WIDTH-1:0]   baud_cnt;
    logic                   bit_tick;
    logic                   baud_clear;
    logic                   unused_rd_hi;

    assign unused_rd_hi = ^fifo_rd_data[DATA_WIDTH-1:UART_BYTE_W];
    assign bit_nxt      = bit_idx + 3'd1;

    // The counter is held at zero outside the bit-timed states so START begins at count 0.
    assign baud_clear = (state == ST_IDLE) || (state == ST_POP) || (state == ST_LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud (
        .clk      (clk),
        .rst      (uart_rst),
        .clear    (baud_clear),
        .count    (baud_cnt),
        .bit_tick (bit_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;
    assign parity_bit = (^shift_reg) ^ PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (uart_rst) begin
            state      <= ST_IDLE;
            txd        <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state      <= ST_POP;
                        fifo_rd_en <= 1'b1;
                        tx_busy    <= 1'b1;
                    end
                end
                ST_POP: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_reg <= fifo_rd_data[UART_BYTE_W-1:0];
                    state     <= ST_START;
                    txd       <= 1'b0;
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        txd     <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state    <= ST_PARITY;
                            txd      <= parity_bit;
`else
                            state    <= ST_STOP;
                            txd      <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx <= bit_nxt;
                            txd     <= shift_reg[bit_nxt];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        state    <= ST_STOP;
                        txd      <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    // Registered pulse: raised one cycle early so it lands on the final stop cycle.
                    tx_done <= (stop_idx == LAST_STOP) && (baud_cnt == PRE_LAST);
                    if (bit_tick) begin
                        if (stop_idx == LAST_STOP) begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - directed bench for uart_tx_fifo_drain
// Defining UART_TX_PARITY_EN switches frame length and adds the parity frame test.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 44;
`else
    localparam int FRAME = 40;
`endif

    logic        clk          = 1'b0;
    logic        uart_rst     = 1'b1;
    logic        tx_en        = 1'b0;
    logic        fifo_empty   = 1'b1;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        fifo_rd_en;
    logic        txd;
    logic        tx_busy;
    logic        tx_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] fifo_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(
        .DATA_WIDTH   (32),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (1),
        .CNT_WIDTH    (16)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD   (1'b0)
`endif
    ) dut (
        .clk          (clk),
        .uart_rst     (uart_rst),
        .tx_en        (tx_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    // FIFO model: registered read data one cycle after the pop, junk in the upper bits.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_rd_data = {24'hC0FFEE, fifo_q.pop_front()};
            fifo_empty   = (fifo_q.size() == 0);
        end
    end

    function automatic logic exp_txd(input logic [7:0] b, input int k);
        int n;
        n = k / CPB;
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
        if (n == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic int frame_errs(input logic [127:0] t, input int base, input logic [7:0] b);
        int n;
        n = 0;
        for (int k = 0; k < FRAME; k++)
            if (t[base+k] !== exp_txd(b, k)) n++;
        return n;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        uart_rst = 1'b1;
        tx_en    = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        uart_rst = 1'b0;
    endtask

    task automatic capture(input int n, output logic [127:0] t_txd, output logic [127:0] t_busy,
                           output logic [127:0] t_done, output logic [127:0] t_rd);
        t_txd = '0; t_busy = '0; t_done = '0; t_rd = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t_txd[i]  = txd;
            t_busy[i] = tx_busy;
            t_done[i] = tx_done;
            t_rd[i]   = fifo_rd_en;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        uart_rst = 1'b1;
        tx_en    = 1'b1;
        push(8'h12);
        repeat (3) @(negedge clk);
        vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b expected 1", txd); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    endtask

    task automatic test_single_frame();
        logic [127:0] t_txd, t_busy, t_done, t_rd;
        int e;
        do_reset();
        push(8'h55);
        tx_en = 1'b1;
        capture(FRAME + 4, t_txd, t_busy, t_done, t_rd);
        tx_en = 1'b0;
        vectors++; if (t_rd[1:0] !== 2'b01) begin miscompares++; $display("FAIL single_pop_timing: got %b expected 01", t_rd[1:0]); end
        vectors++; if (t_txd[2:0] !== 3'b011) begin miscompares++; $display("FAIL single_start_latency: got %b expected 011", t_txd[2:0]); end
        e = frame_errs(t_txd, 2, 8'h55);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL single_frame_bits: %0d wrong cycles, expected 0", e); end
        vectors++; if (t_done[FRAME+1] !== 1'b1) begin miscompares++; $display("FAIL single_done_pos: got %b expected 1", t_done[FRAME+1]); end
        vectors++; if ($countones(t_done) !== 1) begin miscompares++; $display("FAIL single_done_count: got %0d expected 1", $countones(t_done)); end
        vectors++; if ($countones(t_busy) !== FRAME + 2) begin miscompares++; $display("FAIL single_busy_len: got %0d expected %0d", $countones(t_busy), FRAME + 2); end
        vectors++; if ({t_busy[FRAME+2], t_txd[FRAME+2]} !== 2'b01) begin miscompares++; $display("FAIL single_after: got busy,txd=%b expected 01", {t_busy[FRAME+2], t_txd[FRAME+2]}); end
        vectors++; if ($countones(t_rd) !== 1) begin miscompares++; $display("FAIL single_pop_count: got %0d expected 1", $countones(t_rd)); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] t_txd, t_busy, t_done, t_rd;
        int e;
        do_reset();
        push(8'hA3);
        push(8'h0F);
        tx_en = 1'b1;
        capture(2 * FRAME + 10, t_txd, t_busy, t_done, t_rd);
        tx_en = 1'b0;
        e = frame_errs(t_txd, 2, 8'hA3);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL b2b_frame1: %0d wrong cycles, expected 0", e); end
        vectors++; if (t_txd[FRAME+2 +: 4] !== 4'b0111) begin miscompares++; $display("FAIL b2b_gap: got %b expected 0111", t_txd[FRAME+2 +: 4]); end
        e = frame_errs(t_txd, FRAME + 5, 8'h0F);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL b2b_frame2: %0d wrong cycles, expected 0", e); end
        vectors++; if ($countones(t_rd) !== 2) begin miscompares++; $display("FAIL b2b_pop_count: got %0d expected 2", $countones(t_rd)); end
        vectors++; if (t_rd[FRAME+3] !== 1'b1) begin miscompares++; $display("FAIL b2b_second_pop: got %b expected 1", t_rd[FRAME+3]); end
        vectors++; if ($countones(t_done) !== 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", $countones(t_done)); end
    endtask

    task automatic test_empty_idle();
        logic [127:0] t_txd, t_busy, t_done, t_rd;
        do_reset();
        tx_en = 1'b1;
        capture(100, t_txd, t_busy, t_done, t_rd);
        tx_en = 1'b0;
        vectors++; if ($countones(t_rd) !== 0) begin miscompares++; $display("FAIL empty_pop: got %0d pops expected 0", $countones(t_rd)); end
        vectors++; if (t_txd[99:0] !== {100{1'b1}}) begin miscompares++; $display("FAIL empty_txd: got %0d low cycles expected 0", 100 - $countones(t_txd[99:0])); end
        vectors++; if ($countones(t_busy) !== 0) begin miscompares++; $display("FAIL empty_busy: got %0d busy cycles expected 0", $countones(t_busy)); end
    endtask

    task automatic test_tx_en_drop();
        logic [127:0] t_txd, t_busy, t_rd;
        int e;
        do_reset();
        push(8'hFF);
        push(8'h12);
        tx_en = 1'b1;
        t_txd = '0; t_busy = '0; t_rd = '0;
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            @(negedge clk);
            t_txd[i]  = txd;
            t_busy[i] = tx_busy;
            t_rd[i]   = fifo_rd_en;
            if (i == 19) tx_en = 1'b0;
        end
        e = frame_errs(t_txd, 2, 8'hFF);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL drop_frame: %0d wrong cycles, expected 0", e); end
        vectors++; if ($countones(t_rd) !== 1) begin miscompares++; $display("FAIL drop_pop_count: got %0d expected 1", $countones(t_rd)); end
        vectors++; if (fifo_q.size() !== 1) begin miscompares++; $display("FAIL drop_fifo_left: got %0d expected 1", fifo_q.size()); end
        vectors++; if (t_busy[FRAME+2 +: 20] !== 20'h0) begin miscompares++; $display("FAIL drop_busy_after: got %h expected 0", t_busy[FRAME+2 +: 20]); end
        flush();
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] t_txd, t_busy, t_done, t_rd;
        int e;
        do_reset();
        push(8'h00);
        push(8'h3C);
        tx_en = 1'b1;
        repeat (28) @(negedge clk);
        vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL rst_mid_bit5: got %b expected 0", txd); end
        uart_rst = 1'b1;
        @(negedge clk);
        uart_rst = 1'b0;
        vectors++; if ({txd, tx_busy, fifo_rd_en} !== 3'b100) begin miscompares++; $display("FAIL rst_mid_after: got txd,busy,rd=%b expected 100", {txd, tx_busy, fifo_rd_en}); end
        @(negedge clk);
        vectors++; if ({fifo_rd_en, tx_busy} !== 2'b11) begin miscompares++; $display("FAIL rst_mid_repop: got rd,busy=%b expected 11", {fifo_rd_en, tx_busy}); end
        capture(FRAME + 2, t_txd, t_busy, t_done, t_rd);
        tx_en = 1'b0;
        e = frame_errs(t_txd, 1, 8'h3C);
        vectors++; if (e !== 0) begin miscompares++; $display("FAIL rst_mid_frame: %0d wrong cycles, expected 0", e); end
        vectors++; if (t_done[FRAME] !== 1'b1) begin miscompares++; $display("FAIL rst_mid_done: got %b expected 1", t_done[FRAME]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [127:0] t_txd, t_busy, t_done, t_rd;
        do_reset();
        push(8'h07);
        tx_en = 1'b1;
        capture(FRAME + 4, t_txd, t_busy, t_done, t_rd);
        tx_en = 1'b0;
        vectors++; if (t_txd[2+32 +: 4] !== 4'b0000) begin miscompares++; $display("FAIL par_bit7: got %b expected 0000", t_txd[2+32 +: 4]); end
        vectors++; if (t_txd[2+36 +: 4] !== 4'b1111) begin miscompares++; $display("FAIL par_bit: got %b expected 1111", t_txd[2+36 +: 4]); end
        vectors++; if (t_done[2+43] !== 1'b1) begin miscompares++; $display("FAIL par_done_pos: got %b expected 1", t_done[2+43]); end
        vectors++; if ($countones(t_busy) !== 46) begin miscompares++; $display("FAIL par_busy_len: got %0d expected 46", $countones(t_busy)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_idle();
        test_tx_en_drop();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
